// File: rtl/llc_snoop_responder.sv
// Snoop-side responder for the LLC: looks up the tag/MESI array, writes back
// Modified lines when the snoop demands it, applies the MESI update and reports NOHIT/HIT/HITM.
module llc_snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              lk_req,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_ack,
  input  logic              lk_hit,
  input  logic [1:0]        lk_mesi,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_done,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [1:0]        upd_mesi,
  output logic              res_valid,
  output logic [1:0]        res_code,
  output logic [31:0]       num_snoops,
  output logic [31:0]       num_hitm
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RWIM = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [1:0] RES_NOHIT = 2'b00;
  localparam logic [1:0] RES_HIT = 2'b01;
  localparam logic [1:0] RES_HITM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_DECIDE,
    S_WB,
    S_UPDATE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        mesi_q;
  logic [1:0]        new_mesi_q;
  logic [1:0]        code_q;

  function automatic logic [1:0] next_mesi(input logic [1:0] op, input logic [1:0] mesi);
    logic [1:0] nm;
    nm = mesi;
    case (op)
      OP_READ:  nm = (mesi == MESI_I) ? MESI_I : MESI_S;
      OP_WRITE: nm = mesi;
      OP_RWIM:  nm = MESI_I;
      OP_INV:   nm = MESI_I;
      default:  nm = mesi;
    endcase
    return nm;
  endfunction

  function automatic logic needs_wb(input logic [1:0] op, input logic [1:0] mesi);
    return (mesi == MESI_M) && ((op == OP_READ) || (op == OP_RWIM));
  endfunction

  function automatic logic [1:0] result_code(input logic [1:0] mesi);
    logic [1:0] rc;
    case (mesi)
      MESI_I:  rc = RES_NOHIT;
      MESI_M:  rc = RES_HITM;
      default: rc = RES_HIT;
    endcase
    return rc;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      mesi_q     <= '0;
      new_mesi_q <= '0;
      code_q     <= '0;
      num_snoops <= '0;
      num_hitm   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (snp_valid) begin
            op_q       <= snp_op;
            addr_q     <= {snp_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            num_snoops <= num_snoops + 32'd1;
          end
        end
        S_LOOKUP: begin
          // A miss is folded into state I so DECIDE only sees one encoding.
          if (lk_ack) mesi_q <= lk_hit ? lk_mesi : MESI_I;
        end
        S_DECIDE: begin
          new_mesi_q <= next_mesi(op_q, mesi_q);
          code_q     <= result_code(mesi_q);
        end
        S_RESP: begin
          if (code_q == RES_HITM) num_hitm <= num_hitm + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    snp_ready = 1'b0;
    lk_req    = 1'b0;
    lk_addr   = '0;
    wb_req    = 1'b0;
    wb_addr   = '0;
    upd_valid = 1'b0;
    upd_addr  = '0;
    upd_mesi  = '0;
    res_valid = 1'b0;
    res_code  = '0;
    case (state)
      S_IDLE: begin
        snp_ready = 1'b1;
        if (snp_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        lk_req  = 1'b1;
        lk_addr = addr_q;
        if (lk_ack) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (needs_wb(op_q, mesi_q))                 state_nxt = S_WB;
        else if (next_mesi(op_q, mesi_q) != mesi_q) state_nxt = S_UPDATE;
        else                                        state_nxt = S_RESP;
      end
      S_WB: begin
        wb_req  = 1'b1;
        wb_addr = addr_q;
        if (wb_done) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        upd_valid = 1'b1;
        upd_addr  = addr_q;
        upd_mesi  = new_mesi_q;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        res_code  = code_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Scoreboard bench for llc_snoop_responder: a reference model predicts the
// writeback/update/result events per snoop; a monitor pops and compares them.
module tb_llc_snoop_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        snp_valid = 1'b0;
  logic        snp_ready;
  logic [1:0]  snp_op = '0;
  logic [31:0] snp_addr = '0;
  logic        lk_req;
  logic [31:0] lk_addr;
  logic        lk_ack = 1'b0;
  logic        lk_hit = 1'b0;
  logic [1:0]  lk_mesi = '0;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_done = 1'b0;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic [1:0]  upd_mesi;
  logic        res_valid;
  logic [1:0]  res_code;
  logic [31:0] num_snoops;
  logic [31:0] num_hitm;

  llc_snoop_responder #(.ADDR_W(32), .OFFSET_W(6)) dut (
    .clk(clk), .reset(reset),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack), .lk_hit(lk_hit), .lk_mesi(lk_mesi),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_mesi(upd_mesi),
    .res_valid(res_valid), .res_code(res_code),
    .num_snoops(num_snoops), .num_hitm(num_hitm)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] READ = 2'd0, WRITE = 2'd1, RWIM = 2'd2, INV = 2'd3;
  localparam logic [1:0] MI = 2'd0, MS = 2'd1, ME = 2'd2, MM = 2'd3;
  localparam logic [1:0] EV_WB = 2'd1, EV_UPD = 2'd2, EV_RES = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [1:0]  val;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_snoops = 0;
  logic [31:0] exp_hitm = 0;

  // Reference rules, straight from the MESI snoop table.
  function automatic logic [1:0] ref_next(input logic [1:0] op, input logic [1:0] m);
    if (op == WRITE) return m;
    if (op == READ)  return (m == MI) ? MI : MS;
    return MI;
  endfunction

  function automatic logic ref_wb(input logic [1:0] op, input logic [1:0] m);
    return (m == MM) && (op == READ || op == RWIM);
  endfunction

  function automatic logic [1:0] ref_code(input logic [1:0] m);
    if (m == MI) return 2'd0;
    if (m == MM) return 2'd2;
    return 2'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic mon_cmp(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=0x%0h val=%0d expected none",
               got.kind, got.addr, got.val);
    end else begin
      e = exp_q.pop_front();
      check("event", 64'(got), 64'(e));
    end
  endtask

  // Monitor: turns DUT strobes into events and checks them in order.
  logic wb_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wb_req && !wb_prev) mon_cmp('{kind: EV_WB, addr: wb_addr, val: 2'd0});
        if (upd_valid)          mon_cmp('{kind: EV_UPD, addr: upd_addr, val: upd_mesi});
        if (res_valid)          mon_cmp('{kind: EV_RES, addr: 32'd0, val: res_code});
      end
      wb_prev = wb_req;
    end
  end

  // k: extra LOOKUP cycles before lk_ack; n: wb_req cycles before wb_done.
  task automatic do_snoop(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                          input logic [1:0] mesi, input int k, input int n);
    logic [1:0]  eff, nm, code;
    logic        wb, upd, done;
    logic [31:0] line;
    int          c, lkc, wbc, t;
    eff  = hit ? mesi : MI;
    nm   = ref_next(op, eff);
    wb   = ref_wb(op, eff);
    code = ref_code(eff);
    upd  = (nm != eff);
    line = addr & 32'hFFFF_FFC0;
    if (wb)  exp_q.push_back('{kind: EV_WB, addr: line, val: 2'd0});
    if (upd) exp_q.push_back('{kind: EV_UPD, addr: line, val: nm});
    exp_q.push_back('{kind: EV_RES, addr: 32'd0, val: code});
    if (code == 2'd2) exp_hitm++;

    t = 0;
    while (!snp_ready && t < 50) begin @(negedge clk); t++; end
    if (!snp_ready) begin check("ready_timeout", 0, 1); return; end
    // Stray handshakes while idle must be ignored.
    lk_ack    = 1'($urandom);
    wb_done   = 1'($urandom);
    snp_valid = 1'b1;
    snp_op    = op;
    snp_addr  = addr;
    @(posedge clk);
    exp_snoops++;

    c = 0; lkc = 0; wbc = 0; done = 1'b0;
    while (!done && c < 300) begin
      @(negedge clk);
      snp_valid = 1'b0;
      snp_addr  = $urandom;
      snp_op    = 2'($urandom);
      lk_ack    = 1'b0;
      wb_done   = 1'b0;
      lk_hit    = 1'($urandom);
      lk_mesi   = 2'($urandom);
      if (c == 0) check("num_snoops", 64'(num_snoops), 64'(exp_snoops));
      if (res_valid) begin
        check("latency", 64'(c + 1), 64'(3 + k + (upd ? 1 : 0) + (wb ? n : 0)));
        done = 1'b1;
      end else begin
        if (lk_req) begin
          if (lkc == k) begin
            check("lk_addr", 64'(lk_addr), 64'(line));
            lk_ack  = 1'b1;
            lk_hit  = hit;
            lk_mesi = mesi;
          end
          lkc++;
        end
        if (wb_req) begin
          wbc++;
          if (wbc == n) wb_done = 1'b1;
        end
      end
      if (!done) begin @(posedge clk); c++; end
    end
    if (!done) check("res_timeout", 0, 1);
    @(negedge clk);
    lk_ack  = 1'b0;
    wb_done = 1'b0;
    check("num_hitm", 64'(num_hitm), 64'(exp_hitm));
  endtask

  initial begin
    int t;
    // Reset held low for two edges.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 64'({lk_req, wb_req, upd_valid, res_valid}), 64'd0);
    check("rst_counters", 64'({num_snoops, num_hitm}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(snp_ready), 64'd1);

    do_snoop(READ, 32'h1000_0047, 1'b0, ME, 0, 1);
    do_snoop(READ, 32'h2000_0000, 1'b1, ME, 1, 1);
    do_snoop(RWIM, 32'h3000_0080, 1'b1, MM, 0, 4);
    do_snoop(INV,  32'h4000_0100, 1'b1, MM, 2, 1);
    do_snoop(WRITE, 32'h5000_0140, 1'b1, MS, 0, 1);
    do_snoop(READ, 32'h6000_0000, 1'b1, MI, 0, 1);

    for (int i = 0; i < 150; i++)
      do_snoop(2'($urandom), $urandom, 1'($urandom), 2'($urandom),
               $urandom_range(0, 3), $urandom_range(1, 5));

    // Reset during a writeback abandons the operation.
    exp_q.push_back('{kind: EV_WB, addr: 32'h7000_0000, val: 2'd0});
    snp_valid = 1'b1; snp_op = RWIM; snp_addr = 32'h7000_0013;
    @(posedge clk);
    @(negedge clk);
    snp_valid = 1'b0;
    lk_ack = 1'b1; lk_hit = 1'b1; lk_mesi = MM;
    @(negedge clk);
    lk_ack = 1'b0;
    t = 0;
    while (!wb_req && t < 20) begin @(negedge clk); t++; end
    check("wb_reached", 64'(wb_req), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_snoops = 0;
    exp_hitm = 0;
    @(negedge clk);
    check("midrst_strobes", 64'({wb_req, res_valid, upd_valid, lk_req}), 64'd0);
    check("midrst_ready", 64'(snp_ready), 64'd1);
    check("midrst_counters", 64'({num_snoops, num_hitm}), 64'd0);
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    wb_done = 1'b1;
    @(negedge clk);
    wb_done = 1'b0;
    repeat (4) @(negedge clk);
    check("late_wb_done", 64'({wb_req, res_valid, snp_ready}), 64'd1);

    do_snoop(RWIM, 32'h8000_00C5, 1'b1, MM, 1, 2);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
